// File: rtl/scan_reg_file_unit.sv
// scan_reg_file_unit: SIZE x WIDTH register file, one sync write port, two comb read ports.
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-low reset, clears every register
//   write          write enable; wrAddr/wrData select target and value
//   rdAddrA/B      read indices; rdDataA/B are combinational reads
//   scanEn/scanIn/scanOut  serial scan chain, present only when SCAN_CHAIN_EN is defined
// Vectors are [0:N-1], bit 0 is the MSB.
module scan_reg_file_unit #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8,
    localparam int AW   = $clog2(SIZE)
) (
    input  logic            clk,
    input  logic            rst,
`ifdef SCAN_CHAIN_EN
    input  logic            scanEn,
    input  logic            scanIn,
    output logic            scanOut,
`endif
    input  logic            write,
    input  logic [0:AW-1]   wrAddr,
    input  logic [0:WIDTH-1] wrData,
    input  logic [0:AW-1]   rdAddrA,
    input  logic [0:AW-1]   rdAddrB,
    output logic [0:WIDTH-1] rdDataA,
    output logic [0:WIDTH-1] rdDataB
);
    logic [0:SIZE-1][0:WIDTH-1] regs;
    always_ff @(posedge clk)
        if (!rst)
            regs <= '0;
`ifdef SCAN_CHAIN_EN
        // regs[0][0] is the MSB of the flattened array: scanIn lands there, regs[SIZE-1][WIDTH-1] falls off
        else if (scanEn)
            regs <= (SIZE*WIDTH)'({scanIn, regs} >> 1);
`endif
        else if (write)
            regs[wrAddr] <= wrData;
`ifdef SCAN_CHAIN_EN
    assign scanOut = regs[SIZE-1][WIDTH-1];
`endif
    assign rdDataA = regs[rdAddrA];
    assign rdDataB = regs[rdAddrB];
endmodule

// File: tb/tb_scan_reg_file_unit.sv
// tb_scan_reg_file_unit: self-checking bench for scan_reg_file_unit using an expected-value queue.
module tb_scan_reg_file_unit;
    localparam int W = 32;
    localparam int S = 8;
    localparam int A = 3;
    logic clk = 0;
    logic rst = 0;
    logic write = 0;
    logic [A-1:0] wr_addr = '0;
    logic [W-1:0] wr_data = '0;
    logic [A-1:0] rd_addr_a = '0;
    logic [A-1:0] rd_addr_b = '0;
    logic [W-1:0] rd_data_a;
    logic [W-1:0] rd_data_b;
`ifdef SCAN_CHAIN_EN
    logic scan_en = 0;
    logic scan_in = 0;
    logic scan_out;
`endif
    logic [W-1:0] mdl [S];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] e;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_reg_file_unit #(.WIDTH(W), .SIZE(S)) dut (
        .clk(clk),
        .rst(rst),
`ifdef SCAN_CHAIN_EN
        .scanEn(scan_en),
        .scanIn(scan_in),
        .scanOut(scan_out),
`endif
        .write(write),
        .wrAddr(wr_addr),
        .wrData(wr_data),
        .rdAddrA(rd_addr_a),
        .rdAddrB(rd_addr_b),
        .rdDataA(rd_data_a),
        .rdDataB(rd_data_b)
    );

    task automatic do_write(input logic [A-1:0] a, input logic [W-1:0] d);
        @(negedge clk);
        write = 1; wr_addr = a; wr_data = d;
        @(negedge clk);
        write = 0;
        mdl[a] = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1;
        for (int i = 0; i < S; i++) mdl[i] = '0;
    endtask

    // Push expectations for every address on both ports, then read the DUT and pop them.
    task automatic sweep(input string tag);
        for (int i = 0; i < S; i++) begin
            rd_addr_a = A'(i);
            rd_addr_b = A'(S - 1 - i);
            exp_q.push_back(mdl[i]);
            exp_q.push_back(mdl[S - 1 - i]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (rd_data_a !== e) begin
                failures++;
                $display("FAIL %s portA reg%0d got=%h exp=%h", tag, i, rd_data_a, e);
            end
            e = exp_q.pop_front();
            checks++;
            if (rd_data_b !== e) begin
                failures++;
                $display("FAIL %s portB reg%0d got=%h exp=%h", tag, S - 1 - i, rd_data_b, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        for (int i = 0; i < S; i++) mdl[i] = '0;
        sweep("reset_initial");
        for (int i = 0; i < S; i++) do_write(A'(i), 32'hC0DE_0000 + 32'(i) * 32'h0101_0111);
        sweep("prefill");
        do_reset();
        sweep("reset_after_fill");
    endtask

    task automatic test_write_read();
        do_write(3'd3, 32'hDEADBEEF);
        do_write(3'd5, 32'h12345678);
        rd_addr_a = 3'd3; rd_addr_b = 3'd5;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h12345678);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rd_data_a !== e) begin failures++; $display("FAIL wr_rd_A got=%h exp=%h", rd_data_a, e); end
        e = exp_q.pop_front();
        checks++;
        if (rd_data_b !== e) begin failures++; $display("FAIL wr_rd_B got=%h exp=%h", rd_data_b, e); end
        sweep("write_read");
    endtask

    task automatic test_read_during_write();
        do_write(3'd2, 32'h1111_1111);
        @(negedge clk);
        write = 1; wr_addr = 3'd2; wr_data = 32'h2222_2222;
        rd_addr_a = 3'd2; rd_addr_b = 3'd2;
        exp_q.push_back(32'h1111_1111);
        exp_q.push_back(32'h1111_1111);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (rd_data_a !== e) begin failures++; $display("FAIL rdw_before_A got=%h exp=%h", rd_data_a, e); end
        e = exp_q.pop_front();
        checks++;
        if (rd_data_b !== e) begin failures++; $display("FAIL rdw_before_B got=%h exp=%h", rd_data_b, e); end
        @(posedge clk);
        exp_q.push_back(32'h2222_2222);
        exp_q.push_back(32'h2222_2222);
        #1;
        write = 0;
        mdl[2] = 32'h2222_2222;
        e = exp_q.pop_front();
        checks++;
        if (rd_data_a !== e) begin failures++; $display("FAIL rdw_after_A got=%h exp=%h", rd_data_a, e); end
        e = exp_q.pop_front();
        checks++;
        if (rd_data_b !== e) begin failures++; $display("FAIL rdw_after_B got=%h exp=%h", rd_data_b, e); end
    endtask

    task automatic test_write_disabled();
        do_reset();
        @(negedge clk);
        write = 0; wr_addr = 3'd4; wr_data = 32'hFFFF_FFFF;
        repeat (4) @(negedge clk);
        sweep("write_disabled");
    endtask

    task automatic test_reset_vs_write();
        do_write(3'd6, 32'h0F0F_0F0F);
        @(negedge clk);
        rst = 0; write = 1; wr_addr = 3'd1; wr_data = 32'hA5A5_A5A5;
        @(negedge clk);
        rst = 1; write = 0;
        for (int i = 0; i < S; i++) mdl[i] = '0;
        sweep("reset_vs_write");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] d;
        @(negedge clk);
        for (int i = 0; i < S; i++) begin
            d = $urandom;
            write = 1; wr_addr = A'(S - 1 - i); wr_data = d;
            mdl[S - 1 - i] = d;
            @(negedge clk);
        end
        write = 0;
        sweep("back_to_back");
    endtask

`ifdef SCAN_CHAIN_EN
    task automatic test_scan();
        do_reset();
        @(negedge clk);
        scan_en = 1; scan_in = 1;
        write = 1; wr_addr = 3'd7; wr_data = '0;
        for (int n = 1; n <= S * W; n++) begin
            @(posedge clk);
            #1;
            if (n == S * W - 1) begin
                checks++;
                if (scan_out !== 1'b0) begin failures++; $display("FAIL scan_out_early got=%b exp=0", scan_out); end
            end
        end
        checks++;
        if (scan_out !== 1'b1) begin failures++; $display("FAIL scan_out_final got=%b exp=1", scan_out); end
        @(negedge clk);
        scan_en = 0; scan_in = 0; write = 0;
        for (int i = 0; i < S; i++) mdl[i] = '1;
        sweep("scan_fill");
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_read_during_write();
        test_write_disabled();
        test_reset_vs_write();
        test_back_to_back();
`ifdef SCAN_CHAIN_EN
        test_scan();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
